core_step_ctrl: RTL and testbench

- Generates the single-cycle clock-enable that paces the pipelined RV32 core, replacing the derived/gated core clock with a clock-enable scheme on the 100 MHz system clock.
- Sits directly upstream of the core. It takes the debug mode switches, the raw centre/burst buttons and the core `exit` flag, and drives `core_en` plus the step count shown on the 7-segment display.
- Provides free-run at 1/4 and 1/2 rate, debounced single-step, and fixed-length burst stepping. It latches core halt.

---
 rtl/core_step_ctrl.sv | 175 +++++++++++++++++
 tb/tb_core_step_ctrl.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_step_ctrl.sv
// core_step_ctrl
//   Produces the single-cycle clock-enable that paces the pipelined RV32 core
//   from the 100 MHz system clock. Supports free-run at 1/4 and 1/2 rate,
//   debounced single-step, and fixed-length burst stepping. A core exit flag
//   latches the block into HALTED until the next reset.
//
// Ports
//   clock      in   system clock
//   reset_n    in   synchronous active-low reset
//   mode       in   00 run/4, 01 run/2, 10 single-step, 11 burst
//   btn_step   in   raw asynchronous step button
//   btn_burst  in   raw asynchronous burst button
//   halt       in   core exit flag (level)
//   core_en    out  registered clock-enable to the core
//   step_cnt   out  number of enables issued (wraps)
//   halted     out  high while in HALTED
//   burst_busy out  high while a burst is in progress
module core_step_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int DB_CNT_W        = 20,
  parameter int STEP_W          = 16,
  parameter int BURST_LEN       = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [1:0]        mode,
  input  logic              btn_step,
  input  logic              btn_burst,
  input  logic              halt,
  output logic              core_en,
  output logic [STEP_W-1:0] step_cnt,
  output logic              halted,
  output logic              burst_busy
);

  localparam int BTN_STEP  = 0;
  localparam int BTN_BURST = 1;
  localparam int BURST_W   = 8;
  localparam logic [DB_CNT_W-1:0] DB_MAX = DB_CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    ACTIVE,
    HALTED
  } state_t;

  // Button path registers, bit 0 = step, bit 1 = burst
  logic [1:0]          sync1_q, sync2_q;
  logic [1:0]          dbLevel_q, dbLevel_d;
  logic [1:0]          dbPrev_q;
  logic [1:0]          pressPulse_q;
  logic [DB_CNT_W-1:0] dbCnt_q [2];
  logic [DB_CNT_W-1:0] dbCnt_d [2];

  // Control path registers
  state_t              state_q, state_d;
  logic [1:0]          div_q, div_d;
  logic                coreEn_q, coreEn_d;
  logic [STEP_W-1:0]   stepCnt_q, stepCnt_d;
  logic [BURST_W-1:0]  burstCnt_q, burstCnt_d;
  logic                burstBusy_q, burstBusy_d;

  // Debounce next-state: the counter only runs while the synchronised level
  // disagrees with the debounced level, so any bounce back restarts it.
  always_comb begin
    dbLevel_d = dbLevel_q;
    for (int i = 0; i < 2; i++) begin
      dbCnt_d[i] = '0;
      if (sync2_q[i] != dbLevel_q[i]) begin
        if (dbCnt_q[i] == DB_MAX) begin
          dbLevel_d[i] = sync2_q[i];
        end else begin
          dbCnt_d[i] = dbCnt_q[i] + DB_CNT_W'(1);
        end
      end
    end
  end

  // Synchronisers, debounce state and registered press pulses. The press
  // pulse is registered once more after the debounced edge so the enable it
  // produces is fully decoupled from the debounce compare path.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      dbLevel_q    <= '0;
      dbPrev_q     <= '0;
      pressPulse_q <= '0;
      for (int i = 0; i < 2; i++) begin
        dbCnt_q[i] <= '0;
      end
    end else begin
      sync1_q      <= {btn_burst, btn_step};
      sync2_q      <= sync1_q;
      dbLevel_q    <= dbLevel_d;
      dbPrev_q     <= dbLevel_q;
      pressPulse_q <= dbLevel_q & ~dbPrev_q;
      for (int i = 0; i < 2; i++) begin
        dbCnt_q[i] <= dbCnt_d[i];
      end
    end
  end

  // Enable generation and halt latch. halt wins over any same-cycle press or
  // divider tick; a burst is abandoned as soon as mode leaves 11.
  always_comb begin
    state_d     = state_q;
    div_d       = div_q + 2'd1;
    coreEn_d    = 1'b0;
    stepCnt_d   = stepCnt_q + {{(STEP_W-1){1'b0}}, coreEn_q};
    burstCnt_d  = burstCnt_q;
    burstBusy_d = burstBusy_q;

    case (state_q)
      ACTIVE: begin
        if (halt) begin
          state_d     = HALTED;
          burstCnt_d  = '0;
          burstBusy_d = 1'b0;
        end else begin
          case (mode)
            2'b00: coreEn_d = (div_q == 2'd3);
            2'b01: coreEn_d = div_q[0];
            2'b10: coreEn_d = pressPulse_q[BTN_STEP];
            default: begin
              if (burstBusy_q) begin
                // Busy drops one cycle after the final enable is presented.
                if (burstCnt_q == '0) begin
                  burstBusy_d = 1'b0;
                end else if (div_q == 2'd3) begin
                  coreEn_d   = 1'b1;
                  burstCnt_d = burstCnt_q - BURST_W'(1);
                end
              end else if (pressPulse_q[BTN_BURST]) begin
                burstCnt_d  = BURST_W'(BURST_LEN);
                burstBusy_d = 1'b1;
              end
            end
          endcase
          if (mode != 2'b11) begin
            burstCnt_d  = '0;
            burstBusy_d = 1'b0;
          end
        end
      end
      default: begin
        state_d = HALTED;
      end
    endcase
  end

  // Single state register for the control FSM and its registered outputs.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= ACTIVE;
      div_q       <= '0;
      coreEn_q    <= 1'b0;
      stepCnt_q   <= '0;
      burstCnt_q  <= '0;
      burstBusy_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      coreEn_q    <= coreEn_d;
      stepCnt_q   <= stepCnt_d;
      burstCnt_q  <= burstCnt_d;
      burstBusy_q <= burstBusy_d;
    end
  end

  assign core_en    = coreEn_q;
  assign step_cnt   = stepCnt_q;
  assign halted     = (state_q == HALTED);
  assign burst_busy = burstBusy_q;

endmodule

// File: tb/tb_core_step_ctrl.sv
// tb_core_step_ctrl
//   Scoreboard bench for core_step_ctrl. Stimulus pushes each expected
//   enable (cycle number and step count at that moment) into a queue; a
//   separate monitor pops an entry whenever core_en is seen high. A second
//   instance with a 4-bit step counter exercises counter wrap.
module tb_core_step_ctrl;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic        btn_step = 1'b0;
  logic        btn_burst = 1'b0;
  logic        halt = 1'b0;

  logic        coreEn;
  logic [15:0] stepCnt;
  logic        halted;
  logic        burstBusy;
  logic        coreEnB;
  logic [3:0]  stepCntB;
  logic        haltedB;
  logic        burstBusyB;

  typedef struct {
    int cyc;
    int cnt;
  } expT;

  expT expQ[$];
  int  cyc = 0;
  int  checks = 0;
  int  failures = 0;
  int  resetEdge = 0;
  int  expCnt = 0;
  int  countB = 0;
  bit  modelHalted = 1'b0;
  bit  done = 1'b0;

  core_step_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .DB_CNT_W(3),
    .STEP_W(16),
    .BURST_LEN(16)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .mode(mode),
    .btn_step(btn_step),
    .btn_burst(btn_burst),
    .halt(halt),
    .core_en(coreEn),
    .step_cnt(stepCnt),
    .halted(halted),
    .burst_busy(burstBusy)
  );

  core_step_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .DB_CNT_W(3),
    .STEP_W(4),
    .BURST_LEN(16)
  ) dutWrap (
    .clock(clock),
    .reset_n(reset_n),
    .mode(mode),
    .btn_step(btn_step),
    .btn_burst(btn_burst),
    .halt(halt),
    .core_en(coreEnB),
    .step_cnt(stepCntB),
    .halted(haltedB),
    .burst_busy(burstBusyB)
  );

  always #5 clock = ~clock;

  // Edge counter: after posedge k, cyc == k.
  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: every enable must match the head of the scoreboard queue.
  initial begin
    expT e;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        countB = 0;
      end else if (coreEnB) begin
        countB = countB + 1;
      end
      if (coreEn === 1'b1) begin
        checks++;
        if (expQ.size() == 0) begin
          failures++;
          $display("[TB] FAIL unexpectedEn: got core_en=1 at cycle %0d, expected no enable", cyc);
        end else begin
          e = expQ.pop_front();
          if (e.cyc != cyc || e.cnt != int'(stepCnt)) begin
            failures++;
            $display("[TB] FAIL enableEvent: got cycle %0d step_cnt %0d, expected cycle %0d step_cnt %0d",
                     cyc, stepCnt, e.cyc, e.cnt);
          end
        end
      end
    end
  end

  // Safety net so the run always ends.
  initial begin
    #200000;
    if (!done) begin
      failures++;
      $display("[TB] FAIL watchdog: got no completion, expected end of sequence");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic pushEn(input int c);
    expT e;
    e.cyc = c;
    e.cnt = expCnt;
    expQ.push_back(e);
    expCnt++;
  endtask

  // Advance n cycles; in run modes predict the enable from the divider phase
  // (divider is 0 right after the last reset edge).
  task automatic applyStimulus(input int n);
    int k;
    repeat (n) begin
      k = cyc - resetEdge;
      if (!modelHalted) begin
        if (mode == 2'b00 && (k % 4) == 3) pushEn(cyc + 1);
        if (mode == 2'b01 && (k % 2) == 1) pushEn(cyc + 1);
      end
      @(posedge clock);
      #1;
    end
  endtask

  task automatic tickTo(input int target);
    while (cyc < target) applyStimulus(1);
  endtask

  function automatic int nextAligned(input int e);
    int x;
    x = e;
    while (((x - resetEdge) % 4) != 0) x++;
    return x;
  endfunction

  task automatic doReset();
    checkOutput("preResetQueue", expQ.size(), 0);
    reset_n = 1'b0;
    modelHalted = 1'b0;
    expCnt = 0;
    repeat (3) begin
      @(posedge clock);
      #1;
    end
    checkOutput("rstCoreEn", int'(coreEn), 0);
    checkOutput("rstStepCnt", int'(stepCnt), 0);
    checkOutput("rstHalted", int'(halted), 0);
    checkOutput("rstBurstBusy", int'(burstBusy), 0);
    checkOutput("rstStepCntB", int'(stepCntB), 0);
    resetEdge = cyc;
    reset_n = 1'b1;
  endtask

  // Step press: optional bounce, then stable high; the enable arrives
  // 2 (sync) + 4 (debounce) + 1 (pulse) + 1 (core_en) cycles later.
  task automatic pressStep(input bit bounce);
    int s;
    if (bounce) begin
      for (int i = 0; i < 8; i++) begin
        btn_step = ((i / 2) % 2 == 0);
        applyStimulus(1);
      end
    end
    btn_step = 1'b1;
    s = cyc;
    if (mode == 2'b10 && !modelHalted) pushEn(s + 8);
    applyStimulus(10);
    btn_step = 1'b0;
    applyStimulus(10);
  endtask

  task automatic pressBurst();
    btn_burst = 1'b1;
    applyStimulus(10);
    btn_burst = 1'b0;
    applyStimulus(10);
  endtask

  initial begin
    int r;
    int s;
    int e1;
    $display("[TB] start");

    // Run/4 from reset
    mode = 2'b00;
    doReset();
    applyStimulus(41);
    checkOutput("run4StepCnt", int'(stepCnt), 10);

    // Run/2, then back to run/4 without a double pulse
    mode = 2'b01;
    applyStimulus(20);
    checkOutput("run2StepCnt", int'(stepCnt), 20);
    mode = 2'b00;
    applyStimulus(8);
    checkOutput("switchStepCnt", int'(stepCnt), 22);
    checkOutput("runQueueEmpty", expQ.size(), 0);

    // Single-step with bounce, then clean presses; burst ignored in mode 10
    mode = 2'b10;
    applyStimulus(2);
    pressStep(1'b1);
    checkOutput("step1Cnt", int'(stepCnt), 23);
    pressStep(1'b0);
    checkOutput("step2Cnt", int'(stepCnt), 24);
    pressStep(1'b0);
    checkOutput("step3Cnt", int'(stepCnt), 25);
    pressBurst();
    checkOutput("burstInStepMode", int'(stepCnt), 25);

    // Full burst; second press (with step held) mid-burst is ignored
    mode = 2'b11;
    doReset();
    r = resetEdge;
    btn_burst = 1'b1;
    for (int i = 0; i < 16; i++) pushEn(r + 12 + 4 * i);
    applyStimulus(7);
    checkOutput("busyBeforeLoad", int'(burstBusy), 0);
    applyStimulus(1);
    checkOutput("busyAfterLoad", int'(burstBusy), 1);
    applyStimulus(2);
    btn_burst = 1'b0;
    applyStimulus(10);
    btn_burst = 1'b1;
    btn_step = 1'b1;
    applyStimulus(10);
    btn_burst = 1'b0;
    btn_step = 1'b0;
    applyStimulus(10);
    tickTo(r + 72);
    checkOutput("busyAtLastEn", int'(burstBusy), 1);
    checkOutput("cntAtLastEn", int'(stepCnt), 15);
    applyStimulus(1);
    checkOutput("busyAfterBurst", int'(burstBusy), 0);
    checkOutput("burstStepCnt", int'(stepCnt), 16);
    checkOutput("busyAfterBurstB", int'(burstBusyB), 0);
    applyStimulus(12);
    checkOutput("burstIdleCnt", int'(stepCnt), 16);

    // Abort a burst after five enables by leaving mode 11
    mode = 2'b11;
    doReset();
    r = resetEdge;
    btn_burst = 1'b1;
    for (int i = 0; i < 5; i++) pushEn(r + 12 + 4 * i);
    applyStimulus(10);
    btn_burst = 1'b0;
    applyStimulus(10);
    tickTo(r + 28);
    mode = 2'b10;
    applyStimulus(1);
    checkOutput("abortBusy", int'(burstBusy), 0);
    checkOutput("abortStepCnt", int'(stepCnt), 5);
    applyStimulus(20);
    mode = 2'b11;
    applyStimulus(20);
    checkOutput("abortNoResume", int'(stepCnt), 5);
    checkOutput("abortBusyIdle", int'(burstBusy), 0);

    // Simultaneous step and burst press in mode 11: burst wins
    btn_burst = 1'b1;
    btn_step = 1'b1;
    s = cyc;
    e1 = nextAligned(s + 9);
    for (int i = 0; i < 16; i++) pushEn(e1 + 4 * i);
    applyStimulus(10);
    btn_burst = 1'b0;
    btn_step = 1'b0;
    tickTo(e1 + 61);
    checkOutput("bothPressBusy", int'(burstBusy), 0);
    checkOutput("bothPressCnt", int'(stepCnt), 21);

    // Halt has priority over a same-cycle divider tick and is sticky
    mode = 2'b00;
    doReset();
    applyStimulus(7);
    checkOutput("haltedBefore", int'(halted), 0);
    halt = 1'b1;
    modelHalted = 1'b1;
    applyStimulus(1);
    halt = 1'b0;
    checkOutput("haltedSet", int'(halted), 1);
    checkOutput("haltCoreEn", int'(coreEn), 0);
    checkOutput("haltStepCnt", int'(stepCnt), 1);
    mode = 2'b10;
    pressStep(1'b0);
    mode = 2'b11;
    pressBurst();
    mode = 2'b01;
    applyStimulus(20);
    checkOutput("haltedHeld", int'(halted), 1);
    checkOutput("haltedHeldB", int'(haltedB), 1);
    checkOutput("haltFrozenCnt", int'(stepCnt), 1);
    checkOutput("haltNoBurst", int'(burstBusy), 0);
    mode = 2'b00;
    doReset();
    applyStimulus(13);
    checkOutput("resumeHalted", int'(halted), 0);
    checkOutput("resumeStepCnt", int'(stepCnt), 3);

    // Step counter wrap on the 4-bit instance
    mode = 2'b01;
    doReset();
    applyStimulus(33);
    checkOutput("wrapCntA16", int'(stepCnt), 16);
    checkOutput("wrapCntB0", int'(stepCntB), 0);
    applyStimulus(2);
    checkOutput("wrapCntA17", int'(stepCnt), 17);
    checkOutput("wrapCntB1", int'(stepCntB), 1);
    checkOutput("wrapEnCountB", countB, 17);

    checkOutput("finalQueueEmpty", expQ.size(), 0);
    done = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
